// File: rtl/strand_issue_scheduler_pkg.sv
// Shared strand-count constants for the issue scheduler, plus the helper that
// sizes the per-strand hold-off counters.
package strand_issue_scheduler_pkg;

    localparam int STRANDS_PER_CORE    = 4;
    localparam int STRAND_INDEX_WIDTH  = 2;
    localparam int LONG_LATENCY_CYCLES = 3;

    function automatic int hold_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/strand_issue_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the first request strictly after the
// pointer wins, wrapping modulo N, so the last winner gets lowest priority.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(pointer) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/strand_issue_scheduler.sv
// Picks one eligible strand per cycle for decode, with round-robin fairness,
// long-latency hold-off, suspend/resume parking and rollback squash.
module strand_issue_scheduler
    import strand_issue_scheduler_pkg::*;
#(
    parameter int STRANDS      = STRANDS_PER_CORE,
    parameter int IDX_W        = STRAND_INDEX_WIDTH,
    parameter int LONG_LATENCY = LONG_LATENCY_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STRANDS-1:0] cr_strand_enable,
    input  logic [STRANDS-1:0] if_instruction_valid,
    input  logic [STRANDS-1:0] if_long_latency,
    output logic [STRANDS-1:0] ss_instruction_req,
    output logic               ss_valid,
    output logic [IDX_W-1:0]   ss_strand,
    input  logic               ds_stall,
    input  logic [STRANDS-1:0] suspend_strand,
    input  logic [STRANDS-1:0] resume_strand,
    input  logic [STRANDS-1:0] rb_rollback
);

    localparam int HOLD_W = hold_width(LONG_LATENCY);

    logic [STRANDS-1:0] suspended;
    logic [HOLD_W-1:0]  hold [STRANDS];
    logic [STRANDS-1:0] hold_busy;
    logic [STRANDS-1:0] eligible;
    logic [STRANDS-1:0] arb_req;
    logic [STRANDS-1:0] grant;
    logic [IDX_W-1:0]   pointer;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    always_comb begin
        hold_busy = '0;
        for (int i = 0; i < STRANDS; i++) begin
            hold_busy[i] = (hold[i] != '0);
        end
    end

    assign eligible = cr_strand_enable & if_instruction_valid & ~suspended
                    & ~hold_busy & ~rb_rollback;

    // A stalled decode stage suppresses every request so nothing is popped.
    assign arb_req = ds_stall ? '0 : eligible;

    rr_arbiter #(
        .N     (STRANDS),
        .IDX_W (IDX_W)
    ) u_arbiter (
        .req     (arb_req),
        .pointer (pointer),
        .grant   (grant),
        .index   (grant_idx),
        .any     (grant_any)
    );

    assign ss_instruction_req = grant;

    // A fresh grant replaces whatever was registered; otherwise a rollback of
    // the registered strand squashes it even while decode is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_valid  <= 1'b0;
            ss_strand <= '0;
            pointer   <= '0;
        end else if (grant_any) begin
            ss_valid  <= 1'b1;
            ss_strand <= grant_idx;
            pointer   <= grant_idx;
        end else if (ss_valid && rb_rollback[ss_strand]) begin
            ss_valid  <= 1'b0;
        end else if (!ds_stall) begin
            ss_valid  <= 1'b0;
        end
    end

    // Disable and rollback both wipe a strand's parking state outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            suspended <= '0;
            for (int i = 0; i < STRANDS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STRANDS; i++) begin
                if (!cr_strand_enable[i] || rb_rollback[i]) begin
                    suspended[i] <= 1'b0;
                    hold[i]      <= '0;
                end else begin
                    if (suspend_strand[i]) begin
                        suspended[i] <= 1'b1;
                    end else if (resume_strand[i]) begin
                        suspended[i] <= 1'b0;
                    end
                    if (grant[i] && if_long_latency[i]) begin
                        hold[i] <= HOLD_W'(LONG_LATENCY);
                    end else if (hold_busy[i]) begin
                        hold[i] <= hold[i] - HOLD_W'(1);
                    end
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset) $onehot0(ss_instruction_req));
    assert property (@(posedge clk) disable iff (reset) (ss_instruction_req & ~eligible) == '0);

endmodule

// File: tb/tb_strand_issue_scheduler.sv
// Directed bench for strand_issue_scheduler: round robin, stall, rollback,
// long-latency hold-off, suspend/resume, disable and mid-operation reset.
module tb_strand_issue_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] cr_strand_enable;
    logic [3:0] if_instruction_valid;
    logic [3:0] if_long_latency;
    logic [3:0] ss_instruction_req;
    logic       ss_valid;
    logic [1:0] ss_strand;
    logic       ds_stall;
    logic [3:0] suspend_strand;
    logic [3:0] resume_strand;
    logic [3:0] rb_rollback;

    int checks;
    int failures;

    strand_issue_scheduler dut (
        .clk                  (clk),
        .reset                (reset),
        .cr_strand_enable     (cr_strand_enable),
        .if_instruction_valid (if_instruction_valid),
        .if_long_latency      (if_long_latency),
        .ss_instruction_req   (ss_instruction_req),
        .ss_valid             (ss_valid),
        .ss_strand            (ss_strand),
        .ds_stall             (ds_stall),
        .suspend_strand       (suspend_strand),
        .resume_strand        (resume_strand),
        .rb_rollback          (rb_rollback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_issue(input string tag, input logic valid, input logic [1:0] strand, input logic [3:0] req);
        check_output({tag, "_valid"}, {7'd0, ss_valid}, {7'd0, valid});
        check_output({tag, "_strand"}, {6'd0, ss_strand}, {6'd0, strand});
        check_output({tag, "_req"}, {4'd0, ss_instruction_req}, {4'd0, req});
    endtask

    initial begin
        checks               = 0;
        failures             = 0;
        reset                = 1'b1;
        cr_strand_enable     = 4'b0000;
        if_instruction_valid = 4'b0000;
        if_long_latency      = 4'b0000;
        ds_stall             = 1'b0;
        suspend_strand       = 4'b0000;
        resume_strand        = 4'b0000;
        rb_rollback          = 4'b0000;

        #12;
        check_issue("reset", 1'b0, 2'd0, 4'b0000);

        // Round robin from pointer 0: 1,2,3,0,1
        cr_strand_enable     = 4'b1111;
        if_instruction_valid = 4'b1111;
        reset                = 1'b0;
        #1;
        check_output("rr_first_req", {4'd0, ss_instruction_req}, 8'h02);
        tick(); check_issue("rr1", 1'b1, 2'd1, 4'b0100);
        tick(); check_issue("rr2", 1'b1, 2'd2, 4'b1000);
        tick(); check_issue("rr3", 1'b1, 2'd3, 4'b0001);
        tick(); check_issue("rr4", 1'b1, 2'd0, 4'b0010);
        tick(); check_issue("rr5", 1'b1, 2'd1, 4'b0100);

        // Stall with strand 3 registered
        tick(); check_issue("pre_stall2", 1'b1, 2'd2, 4'b1000);
        tick(); check_issue("pre_stall3", 1'b1, 2'd3, 4'b0001);
        ds_stall = 1'b1;
        #1;
        check_output("stall_req", {4'd0, ss_instruction_req}, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick(); check_issue("stall_hold", 1'b1, 2'd3, 4'b0000);
        end
        ds_stall = 1'b0;
        #1;
        check_output("stall_release_req", {4'd0, ss_instruction_req}, 8'h01);
        tick(); check_issue("after_stall", 1'b1, 2'd0, 4'b0010);

        // Rollback squash of registered strand 1 under stall
        if_long_latency = 4'b0010;
        tick(); check_issue("rb_setup", 1'b1, 2'd1, 4'b0100);
        if_long_latency = 4'b0000;
        ds_stall        = 1'b1;
        rb_rollback     = 4'b0010;
        #1;
        check_output("rb_stall_req", {4'd0, ss_instruction_req}, 8'h00);
        tick(); check_issue("rb_squash", 1'b0, 2'd1, 4'b0000);
        ds_stall             = 1'b0;
        rb_rollback          = 4'b0000;
        if_instruction_valid = 4'b0010;
        #1;
        check_output("rb_hold_cleared_req", {4'd0, ss_instruction_req}, 8'h02);
        rb_rollback = 4'b0010;
        #1;
        check_output("rb_blocks_grant", {4'd0, ss_instruction_req}, 8'h00);
        tick(); check_issue("rb_no_issue", 1'b0, 2'd1, 4'b0000);
        rb_rollback = 4'b0000;

        // Long latency on strand 2 alone
        if_instruction_valid = 4'b0100;
        if_long_latency      = 4'b0100;
        #1;
        check_output("ll_grant_req", {4'd0, ss_instruction_req}, 8'h04);
        tick(); check_issue("ll_t1", 1'b1, 2'd2, 4'b0000);
        if_long_latency = 4'b0000;
        tick(); check_issue("ll_t2", 1'b0, 2'd2, 4'b0000);
        tick(); check_issue("ll_t3", 1'b0, 2'd2, 4'b0000);
        tick(); check_issue("ll_t4", 1'b0, 2'd2, 4'b0100);
        tick(); check_issue("ll_t5", 1'b1, 2'd2, 4'b0100);

        // Suspend strand 1 while strands 0,1 valid (pointer 2)
        if_instruction_valid = 4'b0011;
        suspend_strand       = 4'b0010;
        #1;
        check_output("sus_req", {4'd0, ss_instruction_req}, 8'h01);
        tick(); check_issue("sus1", 1'b1, 2'd0, 4'b0001);
        suspend_strand = 4'b0000;
        tick(); check_issue("sus2", 1'b1, 2'd0, 4'b0001);
        suspend_strand = 4'b0010;
        resume_strand  = 4'b0010;
        tick(); check_issue("sus_both", 1'b1, 2'd0, 4'b0001);
        suspend_strand = 4'b0000;
        resume_strand  = 4'b0000;
        #1;
        check_output("sus_still_parked", {4'd0, ss_instruction_req}, 8'h01);
        resume_strand = 4'b0010;
        tick(); check_issue("resume", 1'b1, 2'd0, 4'b0010);
        resume_strand = 4'b0000;
        tick(); check_issue("interleave1", 1'b1, 2'd1, 4'b0001);
        tick(); check_issue("interleave0", 1'b1, 2'd0, 4'b0010);

        // All strands disabled
        cr_strand_enable = 4'b0000;
        #1;
        check_output("dis_req", {4'd0, ss_instruction_req}, 8'h00);
        tick(); check_issue("dis", 1'b0, 2'd0, 4'b0000);

        // Reset in the middle of a strand-2 hold-off (pointer 0 before grant)
        cr_strand_enable     = 4'b1111;
        if_instruction_valid = 4'b0100;
        if_long_latency      = 4'b0100;
        #1;
        check_output("rst_setup_req", {4'd0, ss_instruction_req}, 8'h04);
        tick(); check_issue("rst_hold", 1'b1, 2'd2, 4'b0000);
        if_long_latency      = 4'b0000;
        if_instruction_valid = 4'b1101;
        reset                = 1'b1;
        #1;
        check_issue("rst_mid", 1'b0, 2'd0, 4'b0100);
        reset = 1'b0;
        tick(); check_issue("rst_after", 1'b1, 2'd2, 4'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
